// File: rtl/inst_fetch_stream_if.sv
// Load and handshake bundle for inst_fetch_stream.
// The slave modport is the fetch stage. The master modport is the producer/consumer side.
interface inst_fetch_stream_if #(
    parameter int AW    = 3,
    parameter int RUN_W = 8
);
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [31:0]      ld_data;
    logic             start;
    logic [RUN_W-1:0] run_len;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst_data;
    logic [AW-1:0]    inst_pc;
    logic [RUN_W-1:0] issued;
    logic             busy;
    logic             done;

    modport master (
        output ld_en, ld_addr, ld_data, start, run_len, inst_ready,
        input  inst_valid, inst_data, inst_pc, issued, busy, done
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, start, run_len, inst_ready,
        output inst_valid, inst_data, inst_pc, issued, busy, done
    );
endinterface

// File: rtl/inst_fetch_stream.sv
// Instruction fetch stage with a loadable DEPTH-word memory and a PC.
// It streams run_len words over a valid/ready handshake and can optionally follow J/JAL targets.
module inst_fetch_stream #(
    parameter int DEPTH        = 8,
    parameter int AW           = 3,
    parameter int RUN_W        = 8,
    parameter int FOLLOW_JUMPS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_stream_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_pc;
    logic [RUN_W-1:0] r_remaining;
    logic [RUN_W-1:0] r_issued;
    logic             r_valid;
    logic [31:0]      r_data;
    logic [AW-1:0]    r_inst_pc;

    logic             w_idle;
    logic             w_start;
    logic             w_load;
    logic             w_accept;
    logic             w_is_jump;
    logic [AW-1:0]    w_next_pc;
    logic             w_busy;
    logic             w_done;

    assign w_idle   = (r_state == S_IDLE);
    assign w_start  = w_idle && bus.start;
    assign w_accept = r_valid && bus.inst_ready;
    assign w_load   = (r_state == S_RUN) && (r_remaining != '0) &&
                      (!r_valid || bus.inst_ready);

    // The memory is read combinationally, so the jump decode looks at the word at pc directly.
    assign w_is_jump = (FOLLOW_JUMPS != 0) &&
                       ((r_mem[r_pc][31:26] == 6'b000010) ||
                        (r_mem[r_pc][31:26] == 6'b000011));
    assign w_next_pc = w_is_jump ? r_mem[r_pc][AW-1:0] : r_pc + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if ((r_remaining == '0) && (!r_valid || w_accept)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_RUN: begin
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Memory contents survive reset. Only the load port can write them.
    always_ff @(posedge clk) begin
        if (w_idle && bus.ld_en) begin
            r_mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_remaining <= '0;
            r_issued    <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_inst_pc   <= '0;
        end else begin
            if (w_start) begin
                r_pc        <= '0;
                r_remaining <= bus.run_len;
                r_issued    <= '0;
            end else begin
                if (w_accept) begin
                    r_issued <= r_issued + RUN_W'(1);
                end
                if (w_load) begin
                    r_data      <= r_mem[r_pc];
                    r_inst_pc   <= r_pc;
                    r_valid     <= 1'b1;
                    r_remaining <= r_remaining - RUN_W'(1);
                    r_pc        <= w_next_pc;
                end else if (w_accept) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.inst_valid = r_valid;
    assign bus.inst_data  = r_data;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.issued     = r_issued;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
endmodule
